// File: rtl/grid_pkg.sv
// Shared types and constants for the occupancy grid: cell addressing, log-odds word,
// update increments, saturation bounds and the clear-sweep state encoding.
package grid_pkg;

    localparam int X_BITS = 5;
    localparam int Y_BITS = 4;
    localparam int LO_W   = 8;
    localparam int ADDR_W = X_BITS + Y_BITS;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic signed [LO_W-1:0]   logodds_t;
    typedef logic [X_BITS+Y_BITS-1:0] cell_addr_t;

    localparam logodds_t L_FREE = -8'sd3;
    localparam logodds_t L_OCC  = 8'sd9;
    localparam logodds_t L_MIN  = -8'sd64;
    localparam logodds_t L_MAX  = 8'sd63;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clear_state_t;

endpackage

// File: rtl/grid_ram.sv
// 512-entry log-odds register array: one write port, two registered read ports.
// Reads return the pre-write contents when the same entry is written on the same edge.
module grid_ram
    import grid_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_we,
    input  cell_addr_t i_waddr,
    input  logodds_t   i_wdata,
    input  cell_addr_t i_raddr_a,
    output logodds_t   o_rdata_a,
    input  cell_addr_t i_raddr_b,
    output logodds_t   o_rdata_b
);

    logodds_t r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            o_rdata_a <= '0;
            o_rdata_b <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            o_rdata_a <= r_mem[i_raddr_a];
            o_rdata_b <= r_mem[i_raddr_b];
        end
    end

endmodule

// File: rtl/occupancy_grid_updater.sv
// Occupancy grid keeper: saturating log-odds update pipeline with forwarding,
// a query read port and a clear sweep that re-initialises every cell.
module occupancy_grid_updater
    import grid_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [X_BITS-1:0] x_index,
    input  logic [Y_BITS-1:0] y_index,
    input  logic              cell_is_free,
    input  logic              clear,
    input  logic [X_BITS-1:0] rd_x,
    input  logic [Y_BITS-1:0] rd_y,
    output logodds_t          rd_data,
    output logic              clearing,
    output logic              dropped
);

    function automatic logodds_t sat_add(input logodds_t old_v, input logodds_t inc_v);
        logic signed [LO_W:0] sum;
        logic signed [LO_W:0] lo;
        logic signed [LO_W:0] hi;
        sum = {old_v[LO_W-1], old_v} + {inc_v[LO_W-1], inc_v};
        lo  = {L_MIN[LO_W-1], L_MIN};
        hi  = {L_MAX[LO_W-1], L_MAX};
        if (sum > hi)      sat_add = L_MAX;
        else if (sum < lo) sat_add = L_MIN;
        else               sat_add = sum[LO_W-1:0];
    endfunction

    clear_state_t r_state;
    cell_addr_t   r_cnt;
    logic         r_vld_p1;
    logic         r_vld_p2;
    cell_addr_t   r_addr_p1;
    logic         r_free_p1;
    cell_addr_t   r_addr_p2;
    logodds_t     r_res_p2;

    logic       w_accept;
    logic       w_block;
    logic       w_sweep;
    cell_addr_t w_addr_in;
    cell_addr_t w_rd_addr;
    logodds_t   w_ram_old;
    logodds_t   w_old;
    logodds_t   w_res;
    logic       w_we;
    cell_addr_t w_waddr;
    logodds_t   w_wdata;

    // An update arriving on the edge that accepts clear is also discarded, so the
    // sweep never contends with a pipeline write for the single write port.
    assign w_accept  = (r_state == CLR_IDLE) && clear;
    assign w_block   = clearing || w_accept;
    assign w_sweep   = (r_state == CLR_SWEEP);
    assign w_addr_in = {y_index, x_index};
    assign w_rd_addr = {rd_y, rd_x};

    // Stage 1 -> write: old value, forwarded from the previous write when it hits the same cell
    assign w_old   = (r_vld_p2 && (r_addr_p2 == r_addr_p1)) ? r_res_p2 : w_ram_old;
    assign w_res   = sat_add(w_old, r_free_p1 ? L_FREE : L_OCC);
    assign w_we    = w_sweep || r_vld_p1;
    assign w_waddr = w_sweep ? r_cnt : r_addr_p1;
    assign w_wdata = w_sweep ? logodds_t'(0) : w_res;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= CLR_IDLE;
            r_cnt    <= '0;
            clearing <= 1'b0;
            dropped  <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p1 <= write_enable && !w_block;
            r_vld_p2 <= r_vld_p1;
            if (write_enable && w_block) begin
                dropped <= 1'b1;
            end
            case (r_state)
                CLR_IDLE: begin
                    if (clear) begin
                        r_state  <= CLR_SWEEP;
                        r_cnt    <= '0;
                        clearing <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_state  <= CLR_IDLE;
                        clearing <= 1'b0;
                    end
                end
                default: r_state <= CLR_IDLE;
            endcase
        end
    end

    // Stage boundary p1 / p2: data only, qualified by the valids above
    always_ff @(posedge clock) begin
        r_addr_p1 <= w_addr_in;
        r_free_p1 <= cell_is_free;
        r_addr_p2 <= r_addr_p1;
        r_res_p2  <= w_res;
    end

    grid_ram u_ram (
        .i_clk     (clock),
        .i_rst_n   (reset),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (w_addr_in),
        .o_rdata_a (w_ram_old),
        .i_raddr_b (w_rd_addr),
        .o_rdata_b (rd_data)
    );

endmodule

// File: tb/tb_occupancy_grid_updater.sv
// Directed bench for occupancy_grid_updater: vector table of update bursts with
// hand-computed log-odds, plus clear-sweep, drop and reset corner sequences.
module tb_occupancy_grid_updater;
    import grid_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              write_enable = 1'b0;
    logic [X_BITS-1:0] x_index = '0;
    logic [Y_BITS-1:0] y_index = '0;
    logic              cell_is_free = 1'b0;
    logic              clear = 1'b0;
    logic [X_BITS-1:0] rd_x = '0;
    logic [Y_BITS-1:0] rd_y = '0;
    logodds_t          rd_data;
    logic              clearing;
    logic              dropped;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int x;
        int y;
        bit free;
        int n;
        int exp;
    } vec_t;

    vec_t vecs[8];

    occupancy_grid_updater dut (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .x_index      (x_index),
        .y_index      (y_index),
        .cell_is_free (cell_is_free),
        .clear        (clear),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_data      (rd_data),
        .clearing     (clearing),
        .dropped      (dropped)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_cell(input int x, input int y);
        x_index = x[X_BITS-1:0];
        y_index = y[Y_BITS-1:0];
    endtask

    task automatic do_updates(input int x, input int y, input bit free, input int n);
        for (int i = 0; i < n; i++) begin
            write_enable = 1'b1;
            set_cell(x, y);
            cell_is_free = free;
            @(negedge clock);
        end
        write_enable = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic read_cell(input int x, input int y, output int val);
        rd_x = x[X_BITS-1:0];
        rd_y = y[Y_BITS-1:0];
        @(negedge clock);
        val = int'(rd_data);
    endtask

    task automatic scan_nonzero(output int nz);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_x = i[X_BITS-1:0];
            rd_y = i[X_BITS+Y_BITS-1:X_BITS];
            @(negedge clock);
            if (rd_data != 0) nz++;
        end
    endtask

    task automatic pulse_clear_and_time(output int n);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        n = 0;
        while (clearing && n < 600) begin
            n++;
            @(negedge clock);
        end
    endtask

    initial begin
        int v;
        int nz;
        int n;

        vecs[0] = '{x: 3,  y: 2,  free: 1'b0, n: 1,  exp: 9};
        vecs[1] = '{x: 31, y: 15, free: 1'b1, n: 1,  exp: -3};
        vecs[2] = '{x: 5,  y: 5,  free: 1'b0, n: 8,  exp: 63};
        vecs[3] = '{x: 5,  y: 5,  free: 1'b1, n: 30, exp: -27};
        vecs[4] = '{x: 0,  y: 0,  free: 1'b1, n: 25, exp: -64};
        vecs[5] = '{x: 7,  y: 9,  free: 1'b0, n: 7,  exp: 63};
        vecs[6] = '{x: 7,  y: 9,  free: 1'b0, n: 1,  exp: 63};
        vecs[7] = '{x: 10, y: 3,  free: 1'b1, n: 22, exp: -64};

        repeat (3) @(negedge clock);
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_clearing", int'(clearing), 0);
        check("reset_dropped", int'(dropped), 0);
        reset = 1'b1;
        @(negedge clock);
        scan_nonzero(nz);
        check("reset_scan_nonzero", nz, 0);

        for (int i = 0; i < 8; i++) begin
            do_updates(vecs[i].x, vecs[i].y, vecs[i].free, vecs[i].n);
            read_cell(vecs[i].x, vecs[i].y, v);
            check($sformatf("vec%0d_cell_%0d_%0d", i, vecs[i].x, vecs[i].y), v, vecs[i].exp);
        end

        for (int i = 0; i < 6; i++) begin
            write_enable = 1'b1;
            if (i % 2 == 0) begin set_cell(1, 1); cell_is_free = 1'b0; end
            else            begin set_cell(2, 1); cell_is_free = 1'b1; end
            @(negedge clock);
        end
        write_enable = 1'b0;
        repeat (2) @(negedge clock);
        read_cell(1, 1, v);
        check("alt_cell_1_1", v, 27);
        read_cell(2, 1, v);
        check("alt_cell_2_1", v, -9);

        rd_x = 5'd12;
        rd_y = 4'd12;
        write_enable = 1'b1;
        set_cell(12, 12);
        cell_is_free = 1'b0;
        @(negedge clock);
        write_enable = 1'b0;
        @(negedge clock);
        check("rdport_prewrite", int'(rd_data), 0);
        @(negedge clock);
        check("rdport_postwrite", int'(rd_data), 9);

        check("dropped_before_clear", int'(dropped), 0);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        n = 0;
        while (clearing && n < 600) begin
            n++;
            if (n == 50) begin write_enable = 1'b1; set_cell(20, 10); cell_is_free = 1'b0; end
            if (n == 53) write_enable = 1'b0;
            if (n == 100) clear = 1'b1;
            if (n == 101) clear = 1'b0;
            @(negedge clock);
        end
        write_enable = 1'b0;
        clear = 1'b0;
        check("sweep_cycles", n, 512);
        check("sweep_dropped", int'(dropped), 1);
        check("sweep_clearing_done", int'(clearing), 0);
        repeat (3) @(negedge clock);
        scan_nonzero(nz);
        check("sweep_scan_nonzero", nz, 0);

        do_updates(4, 4, 1'b0, 2);
        read_cell(4, 4, v);
        check("pre_reset_cell_4_4", v, 18);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        repeat (99) @(negedge clock);
        check("mid_sweep_clearing", int'(clearing), 1);
        reset = 1'b0;
        #1;
        check("async_reset_clearing", int'(clearing), 0);
        check("async_reset_dropped", int'(dropped), 0);
        check("async_reset_rd_data", int'(rd_data), 0);
        @(negedge clock);
        reset = 1'b1;

        do_updates(6, 6, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            write_enable = 1'b1;
            set_cell(6, 6);
            cell_is_free = 1'b0;
            @(negedge clock);
        end
        write_enable = 1'b0;
        reset = 1'b0;
        #1;
        check("reset_mid_update_rd", int'(rd_data), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        read_cell(6, 6, v);
        check("reset_mid_update_cell", v, 0);
        scan_nonzero(nz);
        check("post_reset_scan_nonzero", nz, 0);

        do_updates(9, 9, 1'b0, 3);
        pulse_clear_and_time(n);
        check("post_reset_sweep_cycles", n, 512);
        check("post_reset_dropped", int'(dropped), 0);
        read_cell(9, 9, v);
        check("post_reset_sweep_cell", v, 0);
        do_updates(3, 2, 1'b0, 1);
        read_cell(3, 2, v);
        check("after_clear_update", v, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
